// File: rtl/gated_reg_pkg.sv
// Shared types and widths for the clock-gated register bank.
package gated_reg_pkg;

   localparam int CNT_W  = 16;
   localparam int HOLD_W = 8;

   typedef enum logic [1:0] {
      GATED   = 2'd0,
      OPEN    = 2'd1,
      HOLDING = 2'd2
   } gate_state_e;

endpackage

// File: rtl/gated_reg_bank_gate_ctrl.sv
// Per-channel gate controller: keeps the clock gate open for HOLD cycles
// after the last effective write, then closes it.
module gate_ctrl
   import gated_reg_pkg::*;
#(
   parameter int HOLD = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic wr,
   output logic gate_en
);

   localparam logic [HOLD_W-1:0] HOLD_L = HOLD_W'(HOLD);

   gate_state_e       state, state_n;
   logic [HOLD_W-1:0] cnt, cnt_n;

   // OPEN is the first cycle after a write, so the gate stays open for
   // exactly HOLD cycles after it; HOLD=0 closes right after the write.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      if (wr) begin
         cnt_n   = HOLD_L;
         state_n = (HOLD_L == '0) ? GATED : OPEN;
      end else if (state != GATED) begin
         cnt_n   = cnt - HOLD_W'(1);
         state_n = (cnt == HOLD_W'(1)) ? GATED : HOLDING;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= GATED;
         cnt   <= '0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
      end
   end

   assign gate_en = wr | (state != GATED);

endmodule

// File: rtl/gated_reg_bank.sv
// Bank of independently written registers with per-channel clock-gate
// enables and a saturating count of gated channel-cycles.
module gated_reg_bank
   import gated_reg_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 5,
   parameter int HOLD     = 4
) (
   input  logic                      CLK,
   input  logic                      RST_N,
   input  logic [CHANNELS-1:0]       En,
   input  logic [WIDTH-1:0]          D_IN,
   input  logic                      DD_MODE,
   input  logic                      CLR_CNT,
   output logic [CHANNELS*WIDTH-1:0] OUT,
   output logic [CHANNELS-1:0]       GATE_EN,
   output logic [CNT_W-1:0]          SAVED_CNT
);

   logic [CHANNELS-1:0][WIDTH-1:0] data_q;
   logic [CHANNELS-1:0]            wr;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      // Data-driven mode drops writes that would store the same value.
      assign wr[g] = En[g] & (~DD_MODE | (D_IN != data_q[g]));

      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N)     data_q[g] <= '0;
         else if (wr[g]) data_q[g] <= D_IN;
      end

      gate_ctrl #(.HOLD(HOLD)) u_gate (
         .clk     (CLK),
         .rst_n   (RST_N),
         .wr      (wr[g]),
         .gate_en (GATE_EN[g])
      );
   end

   assign OUT = data_q;

   logic [CNT_W:0] idle, sum;

   always_comb begin
      idle = '0;
      for (int i = 0; i < CHANNELS; i++)
         idle = idle + {{CNT_W{1'b0}}, ~GATE_EN[i]};
      sum = {1'b0, SAVED_CNT} + idle;
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)        SAVED_CNT <= '0;
      else if (CLR_CNT)  SAVED_CNT <= '0;
      else if (sum[CNT_W]) SAVED_CNT <= '1;
      else               SAVED_CNT <= sum[CNT_W-1:0];
   end

endmodule

// File: tb/tb_gated_reg_bank.sv
// Bench for gated_reg_bank: hand vectors, corner sequences and random
// traffic against a remaining-open-cycles reference model.
module tb_gated_reg_bank;

   localparam int W  = 8;
   localparam int CH = 5;
   localparam int HA = 4;
   localparam int HB = 0;

   logic            CLK = 1'b0;
   logic            RST_N;
   logic [CH-1:0]   En;
   logic [W-1:0]    D_IN;
   logic            DD_MODE, CLR_CNT;
   logic [CH*W-1:0] out_a, out_b;
   logic [CH-1:0]   gate_a, gate_b;
   logic [15:0]     cnt_a, cnt_b;

   always #5 CLK = ~CLK;

   gated_reg_bank #(.WIDTH(W), .CHANNELS(CH), .HOLD(HA)) u_dut (
      .CLK(CLK), .RST_N(RST_N), .En(En), .D_IN(D_IN), .DD_MODE(DD_MODE),
      .CLR_CNT(CLR_CNT), .OUT(out_a), .GATE_EN(gate_a), .SAVED_CNT(cnt_a));

   gated_reg_bank #(.WIDTH(W), .CHANNELS(CH), .HOLD(HB)) u_dut_h0 (
      .CLK(CLK), .RST_N(RST_N), .En(En), .D_IN(D_IN), .DD_MODE(DD_MODE),
      .CLR_CNT(CLR_CNT), .OUT(out_b), .GATE_EN(gate_b), .SAVED_CNT(cnt_b));

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: stored values plus cycles each gate still stays open.
   logic [W-1:0] m_out [CH];
   int           rem_a [CH];
   int           rem_b [CH];
   int           sav_a, sav_b;

   function automatic logic [CH-1:0] m_w();
      logic [CH-1:0] w;
      for (int i = 0; i < CH; i++)
         w[i] = En[i] && (!DD_MODE || D_IN != m_out[i]);
      return w;
   endfunction

   function automatic logic [CH-1:0] m_gate_a();
      logic [CH-1:0] g = m_w();
      for (int i = 0; i < CH; i++) if (rem_a[i] > 0) g[i] = 1'b1;
      return g;
   endfunction

   function automatic logic [CH-1:0] m_gate_b();
      logic [CH-1:0] g = m_w();
      for (int i = 0; i < CH; i++) if (rem_b[i] > 0) g[i] = 1'b1;
      return g;
   endfunction

   function automatic logic [CH*W-1:0] m_pack();
      logic [CH*W-1:0] p;
      for (int i = 0; i < CH; i++) p[i*W +: W] = m_out[i];
      return p;
   endfunction

   task automatic m_reset();
      for (int i = 0; i < CH; i++) begin
         m_out[i] = '0; rem_a[i] = 0; rem_b[i] = 0;
      end
      sav_a = 0; sav_b = 0;
   endtask

   task automatic m_edge();
      logic [CH-1:0] w  = m_w();
      int            ia = CH - $countones(m_gate_a());
      int            ib = CH - $countones(m_gate_b());
      sav_a = CLR_CNT ? 0 : ((sav_a + ia > 65535) ? 65535 : sav_a + ia);
      sav_b = CLR_CNT ? 0 : ((sav_b + ib > 65535) ? 65535 : sav_b + ib);
      for (int i = 0; i < CH; i++) begin
         if (w[i]) begin
            m_out[i] = D_IN; rem_a[i] = HA; rem_b[i] = HB;
         end else begin
            if (rem_a[i] > 0) rem_a[i]--;
            if (rem_b[i] > 0) rem_b[i]--;
         end
      end
   endtask

   logic [CH-1:0] g_a, g_b;

   // Called at posedge+1: drive, check enables, take the edge, check state.
   task automatic step(input logic [CH-1:0] en, input logic [W-1:0] d,
                       input logic dd, input logic clr);
      En = en; D_IN = d; DD_MODE = dd; CLR_CNT = clr;
      #1;
      g_a = gate_a; g_b = gate_b;
      chk("gate_a", gate_a, m_gate_a());
      chk("gate_b", gate_b, m_gate_b());
      @(posedge CLK);
      m_edge();
      #1;
      chk("out_a", out_a, m_pack());
      chk("out_b", out_b, m_pack());
      chk("cnt_a", cnt_a, sav_a);
      chk("cnt_b", cnt_b, sav_b);
   endtask

   typedef struct {
      logic [CH-1:0]   en;
      logic [W-1:0]    d;
      logic            dd;
      logic            clr;
      logic [CH-1:0]   gate;
      logic [CH*W-1:0] out;
      logic [15:0]     cnt;
   } vec_t;

   vec_t          tbl [16];
   logic [8:0]    seq;

   initial begin
      tbl[0]  = '{5'b00001, 8'hA5, 1'b0, 1'b0, 5'b00001, 40'h00_00_00_00_A5, 16'd4};
      tbl[1]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00001, 40'h00_00_00_00_A5, 16'd8};
      tbl[2]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00001, 40'h00_00_00_00_A5, 16'd12};
      tbl[3]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00001, 40'h00_00_00_00_A5, 16'd16};
      tbl[4]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00001, 40'h00_00_00_00_A5, 16'd20};
      tbl[5]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00000, 40'h00_00_00_00_A5, 16'd25};
      tbl[6]  = '{5'b00100, 8'h3C, 1'b0, 1'b0, 5'b00100, 40'h00_00_3C_00_A5, 16'd29};
      tbl[7]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00100, 40'h00_00_3C_00_A5, 16'd33};
      tbl[8]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00100, 40'h00_00_3C_00_A5, 16'd37};
      tbl[9]  = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00100, 40'h00_00_3C_00_A5, 16'd41};
      tbl[10] = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00100, 40'h00_00_3C_00_A5, 16'd45};
      tbl[11] = '{5'b00000, 8'h00, 1'b0, 1'b0, 5'b00000, 40'h00_00_3C_00_A5, 16'd50};
      tbl[12] = '{5'b00100, 8'h3C, 1'b1, 1'b0, 5'b00000, 40'h00_00_3C_00_A5, 16'd55};
      tbl[13] = '{5'b00101, 8'hA5, 1'b1, 1'b0, 5'b00100, 40'h00_00_A5_00_A5, 16'd59};
      tbl[14] = '{5'b00000, 8'h00, 1'b0, 1'b1, 5'b00100, 40'h00_00_A5_00_A5, 16'd0};
      tbl[15] = '{5'b11111, 8'h0F, 1'b0, 1'b0, 5'b11111, 40'h0F_0F_0F_0F_0F, 16'd0};

      // Reset state, and enables follow requests combinationally in reset.
      RST_N = 1'b0; En = '0; D_IN = '0; DD_MODE = 1'b0; CLR_CNT = 1'b0;
      m_reset();
      #3;
      chk("rst_out", out_a, 40'h0);
      chk("rst_gate", gate_a, 5'b00000);
      chk("rst_cnt", cnt_a, 16'h0);
      En = 5'b00011; D_IN = 8'h77;
      #1;
      chk("rst_gate_w", gate_a, 5'b00011);
      @(posedge CLK); #1;
      chk("rst_no_write", out_a, 40'h0);
      chk("rst_no_count", cnt_a, 16'h0);
      En = '0;
      RST_N = 1'b1;

      for (int i = 0; i < 16; i++) begin
         step(tbl[i].en, tbl[i].d, tbl[i].dd, tbl[i].clr);
         chk($sformatf("vec%0d_gate", i), g_a, tbl[i].gate);
         chk($sformatf("vec%0d_out", i), out_a, tbl[i].out);
         chk($sformatf("vec%0d_cnt", i), cnt_a, tbl[i].cnt);
      end

      // Zero-hold instance: gate open only in the write cycle.
      chk("h0_gate_wr", g_b, 5'b11111);
      step('0, 8'h00, 1'b0, 1'b0);
      chk("h0_gate_after", g_b, 5'b00000);
      chk("h0_out", out_b, 40'h0F_0F_0F_0F_0F);

      // Re-write during countdown restarts the hold window.
      for (int i = 0; i < 5; i++) step('0, 8'h00, 1'b0, 1'b0);
      for (int k = 0; k < 9; k++) begin
         if (k == 0)      step(5'b00010, 8'h11, 1'b0, 1'b0);
         else if (k == 3) step(5'b00010, 8'h22, 1'b0, 1'b0);
         else             step('0, 8'h00, 1'b0, 1'b0);
         seq[k] = g_a[1];
      end
      chk("reload_gate_seq", seq, 9'b0_1111_1111);

      // Saturation of the gated-cycle counter, then clear.
      step('0, 8'h00, 1'b0, 1'b1);
      chk("sat_clr", cnt_a, 16'h0);
      for (int i = 0; i < 13106; i++) step('0, 8'h00, 1'b0, 1'b0);
      chk("sat_before", cnt_a, 16'hFFFA);
      step('0, 8'h00, 1'b0, 1'b0);
      step('0, 8'h00, 1'b0, 1'b0);
      chk("sat_reach", cnt_a, 16'hFFFF);
      for (int i = 0; i < 3; i++) step('0, 8'h00, 1'b0, 1'b0);
      chk("sat_hold", cnt_a, 16'hFFFF);
      step('0, 8'h00, 1'b0, 1'b1);
      chk("sat_clr_idle", cnt_a, 16'h0);

      // Reset asserted between edges while a channel is counting down.
      step(5'b00010, 8'h55, 1'b0, 1'b0);
      step('0, 8'h00, 1'b0, 1'b0);
      step('0, 8'h00, 1'b0, 1'b0);
      #2;
      RST_N = 1'b0;
      #1;
      chk("midrst_out", out_a, 40'h0);
      chk("midrst_gate", gate_a, 5'b00000);
      chk("midrst_cnt", cnt_a, 16'h0);
      m_reset();
      @(posedge CLK); #1;
      RST_N = 1'b1;
      step('0, 8'h00, 1'b0, 1'b0);
      chk("postrst_gate", g_a, 5'b00000);

      // Random traffic; small data alphabet makes data-driven hits common.
      for (int i = 0; i < 400; i++)
         step(CH'($urandom), W'($urandom_range(0, 3)), 1'($urandom),
              ($urandom_range(0, 15) == 0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
